// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the RV32I MEM stage and a ready/ack data-memory port.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word accesses without touching the bus).
module lsu_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_memread,
    input  logic              i_memwrite,
    input  logic [2:0]        i_f3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_stall,
    output logic              o_rvalid,
    output logic [31:0]       o_rdata,
    output logic              o_err,
    output logic              o_misalign,
    output logic              o_req,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [3:0]        o_be,
    output logic [31:0]       o_wdata,
    input  logic              i_ack,
    input  logic              i_berr,
    input  logic [31:0]       i_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        f3_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [31:0]       wdata_p0;
    logic              we_p0;
    logic [31:0]       rdata_p1;
    logic              rvalid_p1, err_p1, mis_p1;
    logic              access, trap_now, take_trap, done_ok, done_err, busy;
    logic [1:0]        size_p0;

    // Unused funct3 encodings fall through to word.
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: size_of = SZ_BYTE;
            3'b001, 3'b101: size_of = SZ_HALF;
            default:        size_of = SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_HALF: misaligned = lo[0];
            SZ_WORD: misaligned = |lo;
            default: misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << lo;
            SZ_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SZ_BYTE: lane_wdata = {4{wd[7:0]}};
            SZ_HALF: lane_wdata = {2{wd[15:0]}};
            default: lane_wdata = wd;
        endcase
    endfunction

    // Lane select uses the aligned-down offset so untrapped misaligned halves read their own half.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        logic        sgn;
        sgn = ~f3[2];
        case (size_of(f3))
            SZ_BYTE: begin
                sh = word >> {lo, 3'b000};
                load_extract = {{24{sgn & sh[7]}}, sh[7:0]};
            end
            SZ_HALF: begin
                sh = word >> {lo[1], 4'b0000};
                load_extract = {{16{sgn & sh[15]}}, sh[15:0]};
            end
            default: load_extract = word;
        endcase
    endfunction

    assign access  = i_memread | i_memwrite;
    assign busy    = (state_q == BUSY);
    assign size_p0 = size_of(f3_p0);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_now = misaligned(size_of(i_f3), i_addr[1:0]);
`else
    assign trap_now = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        take_trap = 1'b0;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (trap_now) begin
                        state_d   = DONE;
                        take_trap = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (i_ack) begin
                    state_d  = DONE;
                    done_err = i_berr;
                    done_ok  = ~i_berr;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    done_err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: request capture in IDLE; data only, no reset needed.
    always_ff @(posedge i_clk) begin
        if (state_q == IDLE && access) begin
            f3_p0    <= i_f3;
            addr_p0  <= i_addr;
            wdata_p0 <= i_wdata;
            we_p0    <= i_memwrite;
        end
    end

    // Stage p1: completion status and extracted load data, visible during DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rvalid_p1 <= 1'b0;
            err_p1    <= 1'b0;
            mis_p1    <= 1'b0;
            rdata_p1  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= busy ? cnt_q + 1'b1 : '0;
            rvalid_p1 <= done_ok & ~we_p0;
            err_p1    <= done_err;
            mis_p1    <= take_trap;
            if (done_err || take_trap) begin
                rdata_p1 <= '0;
            end else if (done_ok && !we_p0) begin
                rdata_p1 <= load_extract(f3_p0, addr_p0[1:0], i_rdata);
            end
        end
    end

    // Reset gating keeps the pipeline from stalling while the LSU is held in reset.
    assign o_stall    = i_rst_n & (((state_q == IDLE) & access) | busy);
    assign o_rvalid   = rvalid_p1;
    assign o_err      = err_p1;
    assign o_misalign = mis_p1;
    assign o_rdata    = rdata_p1;
    assign o_req      = busy;
    assign o_we       = busy & we_p0;
    assign o_addr     = busy ? {addr_p0[ADDR_W-1:2], 2'b00} : '0;
    assign o_be       = busy ? byte_en(size_p0, addr_p0[1:0]) : 4'b0000;
    assign o_wdata    = (busy && we_p0) ? lane_wdata(size_p0, wdata_p0) : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes expected completions, a monitor pops on each pulse.
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_memread, i_memwrite;
    logic [2:0]  i_f3;
    logic [31:0] i_addr, i_wdata;
    logic        o_stall, o_rvalid, o_err, o_misalign, o_req, o_we;
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic [3:0]  o_be;
    logic        i_ack, i_berr;
    logic [31:0] i_rdata;

    lsu_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_memread(i_memread), .i_memwrite(i_memwrite),
        .i_f3(i_f3), .i_addr(i_addr), .i_wdata(i_wdata), .o_stall(o_stall),
        .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_err(o_err), .o_misalign(o_misalign),
        .o_req(o_req), .o_we(o_we), .o_addr(o_addr), .o_be(o_be), .o_wdata(o_wdata),
        .i_ack(i_ack), .i_berr(i_berr), .i_rdata(i_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        rvalid;
        logic        err;
        logic        mis;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic rv, input logic er, input logic mi, input logic [31:0] rd);
        exp_t e;
        e.rvalid = rv; e.err = er; e.mis = mi; e.rdata = rd;
        exp_q.push_back(e);
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation.
    always @(negedge i_clk) begin
        if (i_rst_n && (o_rvalid || o_err || o_misalign)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {o_rvalid, o_err, o_misalign}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_rvalid", o_rvalid, e.rvalid);
                chk("mon_err", o_err, e.err);
                chk("mon_misalign", o_misalign, e.mis);
                chk("mon_rdata", o_rdata, e.rdata);
            end
        end
    end

    // One access: accept, waits+1 BUSY cycles (ack on the last if ack set), then DONE.
    task automatic run_acc(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int waits, input bit ack, input bit berr,
                           input logic [31:0] rd, input logic [31:0] ea, input logic [3:0] ebe,
                           input logic [31:0] ewd);
        i_memread = ~wr; i_memwrite = wr; i_f3 = f3; i_addr = addr; i_wdata = wd;
        @(negedge i_clk);
        chk("stall_accept", o_stall, 1);
        chk("req_accept", o_req, 0);
        @(posedge i_clk); #1;
        i_memread = 1'b0; i_memwrite = 1'b0;
        for (int k = 0; k <= waits; k++) begin
            i_ack = ack && (k == waits); i_berr = berr; i_rdata = rd;
            @(negedge i_clk);
            chk("req_busy", o_req, 1);
            chk("stall_busy", o_stall, 1);
            chk("addr_busy", o_addr, ea);
            chk("be_busy", o_be, ebe);
            chk("we_busy", o_we, wr);
            if (wr) chk("wdata_busy", o_wdata, ewd);
            @(posedge i_clk); #1;
        end
        i_ack = 1'b0; i_berr = 1'b0;
        @(negedge i_clk);
        chk("req_done", o_req, 0);
        chk("stall_done", o_stall, 0);
        @(posedge i_clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_memread = 0; i_memwrite = 0; i_f3 = 0; i_addr = 0; i_wdata = 0;
        i_ack = 0; i_berr = 0; i_rdata = 0;
        repeat (2) @(negedge i_clk);
        chk("rst_req", o_req, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_pulses", {o_rvalid, o_err, o_misalign}, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_bus", {o_we, o_be}, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_wdata", o_wdata, 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // LW 0x100, ack in first BUSY cycle
        push(1, 0, 0, 32'hDEADBEEF);
        run_acc(0, 3'b010, 32'h100, 0, 0, 1, 0, 32'hDEADBEEF, 32'h100, 4'b1111, 0);
        // SB 0x203 with 3 wait cycles
        run_acc(1, 3'b000, 32'h203, 32'h12345680, 3, 1, 0, 0, 32'h200, 4'b1000, 32'h80808080);
        // SH 0x102
        run_acc(1, 3'b001, 32'h102, 32'h0000ABCD, 1, 1, 0, 0, 32'h100, 4'b1100, 32'hABCDABCD);
        // LB 0x201 sign-extends lane 1
        push(1, 0, 0, 32'hFFFFFFF1);
        run_acc(0, 3'b000, 32'h201, 0, 0, 1, 0, 32'h0000F100, 32'h200, 4'b0010, 0);
        // LHU 0x202 zero-extends upper half
        push(1, 0, 0, 32'h00008001);
        run_acc(0, 3'b101, 32'h202, 0, 1, 1, 0, 32'h80010000, 32'h200, 4'b1100, 0);
        // LBU 0x003
        push(1, 0, 0, 32'h0000009A);
        run_acc(0, 3'b100, 32'h003, 0, 0, 1, 0, 32'h9A000000, 32'h000, 4'b1000, 0);
        // Timeout: no ack for TO cycles
        push(0, 1, 0, 32'h0);
        run_acc(0, 3'b010, 32'h400, 0, TO - 1, 0, 0, 32'h55555555, 32'h400, 4'b1111, 0);
        // Bus error with ack
        push(0, 1, 0, 32'h0);
        run_acc(0, 3'b010, 32'h404, 0, 0, 1, 1, 32'h12345678, 32'h404, 4'b1111, 0);

        // LH at 0x101
`ifdef LSU_MISALIGN_TRAP_EN
        push(0, 0, 1, 32'h0);
        i_memread = 1'b1; i_f3 = 3'b001; i_addr = 32'h101;
        @(negedge i_clk);
        chk("trap_stall", o_stall, 1);
        @(posedge i_clk); #1;
        i_memread = 1'b0;
        @(negedge i_clk);
        chk("trap_req", o_req, 0);
        chk("trap_stall_done", o_stall, 0);
        @(posedge i_clk); #1;
`else
        push(1, 0, 0, 32'hFFFF8765);
        run_acc(0, 3'b001, 32'h101, 0, 0, 1, 0, 32'h00008765, 32'h100, 4'b0011, 0);
`endif

        // Stray ack in IDLE must be ignored
        i_ack = 1'b1; i_rdata = 32'hFFFFFFFF;
        @(negedge i_clk);
        chk("idle_ack_req", o_req, 0);
        @(posedge i_clk); #1;
        i_ack = 1'b0;
        @(negedge i_clk);
        chk("idle_ack_nopulse", {o_rvalid, o_err}, 0);
        @(posedge i_clk); #1;

        // Reset in the second BUSY cycle
        i_memread = 1'b1; i_f3 = 3'b010; i_addr = 32'h300;
        @(posedge i_clk); #1;
        chk("pre_rst_req", o_req, 1);
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        #1;
        chk("rst_mid_req", o_req, 0);
        chk("rst_mid_stall", o_stall, 0);
        i_memread = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        run_acc(1, 3'b010, 32'h10, 32'hCAFEF00D, 1, 1, 0, 0, 32'h10, 4'b1111, 32'hCAFEF00D);

        repeat (3) @(posedge i_clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
